mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning): AW, 32, address width.
REQ-002 DW, 32, data width.
REQ-003 DATA_FIRST, 1, 1 = data always wins a tie, 0 = round-robin on a tie.
REQ-004 TIMEOUT, 255, maximum cycles spent in REQ+RESP before abort.
REQ-005 The block SHALL use these ports (name, direction, width, meaning):
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- if_req in 1: fetch request; held high until if_done.
- if_addr in AW: fetch address.
- if_done out 1: one-cycle completion pulse to fetch.
- if_rdata out DW: fetch read data, valid while if_done is high.
- d_req in 1: data request; held until d_done.
- d_we in 1: write enable.
- d_size in 3: access size, funct3 encoding.
- d_addr in AW: data address.
- d_wdata in DW: write data.
- d_done out 1: completion pulse to data.
- d_rdata out DW: data read data, valid while d_done is high.
- m_valid out 1: command valid to memory.
- m_ready in 1: memory accepts command.
- m_we out 1: command write enable.
- m_size out 3: command access size.
- m_addr out AW: command address.
- m_wdata out DW: command write data.
- m_rvalid in 1: memory response; asserted for reads and write-acks.
- m_rdata in DW: memory response data.
- busy out 1: high in any state except IDLE.
- err out 1: sticky timeout flag.

Function
REQ-006 FSM states SHALL be IDLE, REQ, RESP, DONE, with one outstanding memory transaction at most.
REQ-007 IDLE transitions:
- If any request is pending, latch the winner's command into the m_* registers, record the owner, go to REQ.
- If no request is pending, stay in IDLE.
REQ-008 Tie-break with DATA_FIRST=1: data wins.
REQ-009 Tie-break with DATA_FIRST=0: grant the requester other than last_owner; last_owner resets to fetch.
REQ-010 Fetch commands SHALL drive m_we=0, m_size=3'b010 and m_wdata=0.
REQ-011 In REQ, m_valid SHALL be held high with stable m_* fields; when m_ready=1, go to RESP at that edge.
REQ-012 In RESP, when m_rvalid=1, register m_rdata into the owner's rdata and go to DONE.
- Reads return data.
- Writes return the m_rdata value unchanged; the requester ignores it.
REQ-013 In DONE, pulse the owner's done for exactly one cycle, then go to IDLE.
- No grant is evaluated in DONE.
- The non-owner's rdata and done SHALL stay 0.
REQ-014 m_ready outside REQ and m_rvalid outside RESP SHALL be ignored.
REQ-015 Minimum latency SHALL be 3 cycles:
- req sampled at edge 0; m_valid high in cycle 1.
- With m_ready in cycle 1 and m_rvalid in cycle 2, done is high in cycle 3.
- The next grant is evaluated in cycle 4.
REQ-016 m_valid SHALL be combinationally independent of m_ready and of the request inputs; all m_* outputs are registers.
REQ-017 A cycle counter SHALL clear on entry to REQ and increment each cycle in REQ or RESP.
REQ-018 When the counter reaches TIMEOUT:
- set err;
- drop m_valid;
- go to DONE with the owner's rdata = 0;
- ignore any late m_rvalid.
REQ-019 err SHALL stay set until reset; operation continues normally after a timeout.
REQ-020 A requester dropping req mid-transaction SHALL NOT abort it; the done pulse is still issued.

Reset
REQ-021 reset=0 SHALL immediately (asynchronously) force:
- state IDLE;
- all outputs 0, including m_valid, if_done, d_done, busy, err, rdata and m_*;
- counter 0;
- last_owner = fetch.
REQ-022 A reset mid-transaction SHALL abandon the transaction without a done pulse.
REQ-023 The first grant SHALL be evaluated on the first rising edge after reset deasserts.

Verification
REQ-024 Single fetch: if_req=1, if_addr=0x10, m_ready=1 immediate, m_rvalid next cycle with m_rdata=0x00500093 -> if_done high exactly in cycle 3, if_rdata=0x00500093.
REQ-025 Tie with DATA_FIRST=1: both requests high at the same edge -> data served first (m_addr=d_addr, m_we=d_we), fetch granted on the cycle after d_done.
REQ-026 Round-robin (DATA_FIRST=0), both requesters held continuously -> grant order after reset is data, fetch, data, fetch.
REQ-027 Backpressure: m_ready held low 5 cycles during REQ -> m_valid and m_addr stable all 5 cycles, single acceptance, one done pulse.
REQ-028 Timeout with TIMEOUT=8: m_rvalid never asserted -> err=1 and a done pulse with rdata=0; a following request completes normally with err still 1.
REQ-029 Reset in RESP: reset low for 1 cycle -> all outputs 0 immediately, no done pulse, a later m_rvalid ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single-outstanding memory command port
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter bit DATA_FIRST = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_we,
  output logic [2:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int            CW     = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [1:0]    state;
  logic          owner_d;   // 1 = data owns the current transaction
  logic          last_d;    // last owner, 1 = data; resets to fetch
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata_q;
  logic          grant_d;
  logic          timeout_hit;
  logic          in_done;

  always_comb begin
    grant_d = d_req;
    if (d_req && if_req) begin
      grant_d = DATA_FIRST ? 1'b1 : !last_d;
    end
  end

  // Fires on the cycle whose closing edge would bring the counter to TIMEOUT.
  assign timeout_hit = (cnt + 1'b1) >= TO_VAL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            state   <= S_REQ;
            owner_d <= grant_d;
            last_d  <= grant_d;
            cnt     <= '0;
            rdata_q <= '0;
            m_valid <= 1'b1;
            if (grant_d) begin
              m_we    <= d_we;
              m_size  <= d_size;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_size  <= 3'b010;
              m_addr  <= if_addr;
              m_wdata <= '0;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            err     <= 1'b1;
            m_valid <= 1'b0;
            rdata_q <= '0;
            state   <= S_DONE;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          cnt <= cnt + 1'b1;
          // A response arriving on the final allowed cycle still completes normally.
          if (m_rvalid) begin
            rdata_q <= m_rdata;
            state   <= S_DONE;
          end else if (timeout_hit) begin
            err     <= 1'b1;
            rdata_q <= '0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign in_done  = (state == S_DONE);
  assign if_done  = in_done && !owner_d;
  assign d_done   = in_done && owner_d;
  assign if_rdata = if_done ? rdata_q : '0;
  assign d_rdata  = d_done ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        if_req, d_req, d_we, m_ready, m_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_size;
  logic        if_done, d_done, m_valid, m_we, busy, err;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  m_size;

  logic        r_rst;
  logic        r_if_done, r_d_done, r_m_valid, r_m_we, r_busy, r_err;
  logic [31:0] r_if_rdata, r_d_rdata, r_m_addr, r_m_wdata;
  logic [2:0]  r_m_size;

  int n_checks = 0;
  int n_errors = 0;
  bit m_err = 0;
  bit rr_q[$];

  mem_arbiter #(.AW(32), .DW(32), .DATA_FIRST(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy), .err(err)
  );

  mem_arbiter #(.AW(32), .DW(32), .DATA_FIRST(1'b0), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .reset(r_rst),
    .if_req(1'b1), .if_addr(32'h100), .if_done(r_if_done), .if_rdata(r_if_rdata),
    .d_req(1'b1), .d_we(1'b1), .d_size(3'b001), .d_addr(32'h200), .d_wdata(32'h55),
    .d_done(r_d_done), .d_rdata(r_d_rdata),
    .m_valid(r_m_valid), .m_ready(1'b1), .m_we(r_m_we), .m_size(r_m_size), .m_addr(r_m_addr),
    .m_wdata(r_m_wdata), .m_rvalid(1'b1), .m_rdata(32'h77), .busy(r_busy), .err(r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (r_rst) begin
      if (r_d_done)  rr_q.push_back(1'b1);
      if (r_if_done) rr_q.push_back(1'b0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_fields"}, {m_we, m_size, m_addr, m_wdata}, 0);
    check({tag, "_done"}, {if_done, d_done}, 0);
    check({tag, "_rdata"}, if_rdata | d_rdata, 0);
    check({tag, "_busy_err"}, {busy, err}, 0);
  endtask

  // Called at a negedge with the DUT idle; the grant happens at the next rising edge.
  // rd = cycles of m_ready low in REQ, vd = cycles of m_rvalid low in RESP.
  task automatic run_txn(input bit add_f, input bit add_d, input int rd, input int vd,
                         input logic [31:0] resp);
    bit          own_d, normal;
    int          t;
    logic [31:0] ea, ew;
    logic [2:0]  es;
    logic        ewe;
    if (add_f && !if_req) begin if_req = 1; if_addr = $urandom; end
    if (add_d && !d_req) begin
      d_req = 1; d_we = 1'($urandom); d_size = 3'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
    end
    if (!if_req && !d_req) begin if_req = 1; if_addr = $urandom; end
    own_d = d_req;
    if (own_d) begin ea = d_addr; ewe = d_we; es = d_size; ew = d_wdata; end
    else begin ea = if_addr; ewe = 0; es = 3'b010; ew = 0; end
    normal = (rd + vd + 2) <= TO;
    t = normal ? rd + vd + 2 : TO;
    for (int c = 1; c <= t; c++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("no_early_done", {if_done, d_done}, 0);
      if (c <= rd + 1) begin
        check("m_valid_req", m_valid, 1);
        check("m_cmd", {m_we, m_size, m_addr, m_wdata}, {ewe, es, ea, ew});
      end else begin
        check("m_valid_resp", m_valid, 0);
      end
      if (c == 1 && $urandom_range(0, 3) == 0) begin
        if (own_d) d_req = 0; else if_req = 0;
      end
      m_ready  = (c == rd + 1) ? 1'b1 : ((c > rd + 1) ? 1'($urandom) : 1'b0);
      m_rvalid = (c == rd + vd + 2) ? 1'b1 : ((c <= rd + 1) ? 1'($urandom) : 1'b0);
      m_rdata  = (c == rd + vd + 2) ? resp : $urandom;
    end
    @(negedge clk);
    if (!normal) m_err = 1;
    check("done_owner", {d_done, if_done}, {own_d, !own_d});
    check("rdata_owner", own_d ? d_rdata : if_rdata, normal ? resp : 32'h0);
    check("rdata_other", own_d ? if_rdata : d_rdata, 0);
    check("err", err, m_err);
    check("m_valid_done", m_valid, 0);
    m_ready  = 1'($urandom);
    m_rvalid = 1'($urandom);
    m_rdata  = $urandom;
    if (own_d) d_req = 0; else if_req = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", {if_done, d_done}, 0);
    check("idle_err", err, m_err);
    m_ready  = 0;
    m_rvalid = 0;
  endtask

  initial begin
    reset = 0; r_rst = 0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1; r_rst = 1;

    if_req = 1; if_addr = 32'h10;
    run_txn(0, 0, 0, 0, 32'h00500093);

    run_txn(1, 1, 2, 1, $urandom);
    run_txn(0, 0, 1, 2, $urandom);

    run_txn(0, 1, 5, 1, $urandom);

    run_txn(1, 0, 0, 50, $urandom);
    run_txn(0, 1, 1, 1, $urandom);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    end

    if (!if_req) begin if_req = 1; if_addr = $urandom; end
    @(negedge clk);
    check("rst_pre_valid", m_valid, 1);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    check("rst_pre_busy", busy, 1);
    #2 reset = 0;
    #1;
    check_all_zero("mid_reset");
    if_req = 0; d_req = 0;
    @(negedge clk);
    reset = 1; m_rvalid = 1; m_rdata = $urandom;
    m_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", {if_done, d_done}, 0);
      check("post_rst_busy", busy, 0);
    end
    m_rvalid = 0;
    run_txn(1, 1, 0, 0, $urandom);

    check("rr_count", rr_q.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < rr_q.size()) check($sformatf("rr_order_%0d", k), rr_q[k], (k % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
